// File: rtl/branch_hazard_ctrl.sv
// Branch resolution in ID: RAW hazard stalls, comparator forwarding, redirect and flush.
// Optional BRANCH_STATS_EN adds branch, taken and stall-cycle counters.
module branch_hazard_ctrl #(
    parameter logic [3:0] NO_BRANCH  = 4'b1000,
    parameter logic [3:0] BEQ        = 4'b0000,
    parameter logic [3:0] BNE        = 4'b0001,
    parameter int         LOAD_STALL = 2,
    parameter int         ALU_STALL  = 1,
    parameter bit         DELAY_SLOT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_branch,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        mem_reg_write,
    input  logic        mem_mem_read,
    input  logic [4:0]  mem_rd,
    input  logic        ext_stall,
    input  logic        bu_taken,
`ifdef BRANCH_STATS_EN
    output logic [31:0] stat_branches,
    output logic [31:0] stat_taken,
    output logic [31:0] stat_stall_cycles,
`endif
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        idex_bubble,
    output logic        ifid_flush,
    output logic        pc_src_branch,
    output logic        fwd_a_sel,
    output logic        fwd_b_sel
);

    typedef enum logic [1:0] {IDLE, STALL, RESOLVE} state_t;

    state_t     state;
    logic [1:0] cnt;
    logic       rst_q;

    logic       is_br, uses_rt, dep_ex, dep_mem;
    logic       load_haz, alu_haz, active;
    logic       stall_now, resolve_now, fwd_en;
    logic [1:0] haz_n;

    always_comb begin
        is_br   = id_branch != NO_BRANCH;
        uses_rt = (id_branch == BEQ) || (id_branch == BNE);
        dep_ex  = (ex_rd != 5'd0) &&
                  ((ex_rd == id_rs) || (uses_rt && ex_rd == id_rt));
        dep_mem = (mem_rd != 5'd0) &&
                  ((mem_rd == id_rs) || (uses_rt && mem_rd == id_rt));
        load_haz = ex_reg_write && ex_mem_read && dep_ex;
        alu_haz  = (ex_reg_write && dep_ex) ||
                   (mem_reg_write && mem_mem_read && dep_mem);
        haz_n    = load_haz ? 2'(LOAD_STALL) : 2'(ALU_STALL);
        // Outputs stay quiet during reset and the cycle right after it
        active   = !rst && !rst_q;
        stall_now = active &&
                    ((state == IDLE && is_br && (load_haz || alu_haz)) ||
                     state == STALL);
        resolve_now = active &&
                      ((state == IDLE && is_br && !load_haz && !alu_haz) ||
                       state == RESOLVE);
        fwd_en = active && ((state == IDLE && is_br) || state == RESOLVE);

        pc_stall      = stall_now && !ext_stall;
        ifid_stall    = stall_now && !ext_stall;
        idex_bubble   = stall_now && !ext_stall;
        pc_src_branch = resolve_now && !ext_stall && bu_taken;
        ifid_flush    = resolve_now && !ext_stall && bu_taken && !DELAY_SLOT;
        fwd_a_sel = fwd_en && mem_reg_write && !mem_mem_read &&
                    (mem_rd != 5'd0) && (mem_rd == id_rs);
        fwd_b_sel = fwd_en && mem_reg_write && !mem_mem_read &&
                    (mem_rd != 5'd0) && (mem_rd == id_rt);
    end

    // cnt holds the stall cycles still owed after the current one
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
            rst_q <= 1'b1;
        end else begin
            rst_q <= 1'b0;
            if (!rst_q && !ext_stall) begin
                unique case (state)
                    IDLE: begin
                        if (is_br && (load_haz || alu_haz)) begin
                            if (haz_n <= 2'd1) begin
                                state <= RESOLVE;
                                cnt   <= 2'd0;
                            end else begin
                                state <= STALL;
                                cnt   <= haz_n - 2'd1;
                            end
                        end
                    end
                    STALL: begin
                        if (cnt <= 2'd1) begin
                            state <= RESOLVE;
                            cnt   <= 2'd0;
                        end else begin
                            cnt <= cnt - 2'd1;
                        end
                    end
                    RESOLVE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches     <= 32'd0;
            stat_taken        <= 32'd0;
            stat_stall_cycles <= 32'd0;
        end else begin
            if (resolve_now && !ext_stall) begin
                stat_branches <= stat_branches + 32'd1;
                if (bu_taken)
                    stat_taken <= stat_taken + 32'd1;
            end
            if (pc_stall)
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl with immediate assertions.
// Output vector order: pc_stall ifid_stall idex_bubble ifid_flush pc_src fwd_a fwd_b.
module tb_branch_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] id_branch;
    logic [4:0] id_rs, id_rt;
    logic       ex_reg_write, ex_mem_read;
    logic [4:0] ex_rd;
    logic       mem_reg_write, mem_mem_read;
    logic [4:0] mem_rd;
    logic       ext_stall, bu_taken;
    logic       pc_stall, ifid_stall, idex_bubble, ifid_flush;
    logic       pc_src_branch, fwd_a_sel, fwd_b_sel;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches, stat_taken, stat_stall_cycles;
`endif

    int errors = 0;
    int checks = 0;

    localparam logic [3:0] NOB  = 4'b1000;
    localparam logic [3:0] BEQ  = 4'b0000;
    localparam logic [3:0] BNE  = 4'b0001;
    localparam logic [3:0] BGTZ = 4'b0100;

    always #5 clk = ~clk;

    branch_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_branch(id_branch),
        .id_rs(id_rs), .id_rt(id_rt),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_rd(mem_rd), .ext_stall(ext_stall), .bu_taken(bu_taken),
`ifdef BRANCH_STATS_EN
        .stat_branches(stat_branches), .stat_taken(stat_taken),
        .stat_stall_cycles(stat_stall_cycles),
`endif
        .pc_stall(pc_stall), .ifid_stall(ifid_stall),
        .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
        .pc_src_branch(pc_src_branch),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
    );

    task automatic set_br(input logic [3:0] br, input logic [4:0] rs,
                          input logic [4:0] rt, input logic tk);
        id_branch = br; id_rs = rs; id_rt = rt; bu_taken = tk;
    endtask

    task automatic set_ex(input logic rw, input logic mr, input logic [4:0] rd);
        ex_reg_write = rw; ex_mem_read = mr; ex_rd = rd;
    endtask

    task automatic set_mem(input logic rw, input logic mr, input logic [4:0] rd);
        mem_reg_write = rw; mem_mem_read = mr; mem_rd = rd;
    endtask

    // Check outputs mid-cycle, then advance to just after the next rising edge
    task automatic step(input string tag, input logic [6:0] exp);
        logic [6:0] got;
        @(negedge clk);
        got = {pc_stall, ifid_stall, idex_bubble, ifid_flush,
               pc_src_branch, fwd_a_sel, fwd_b_sel};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%b expected=%b", tag, got, exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ext_stall = 1'b0;
        set_br(BEQ, 5'd5, 5'd0, 1'b1);
        set_ex(1'b1, 1'b1, 5'd5);
        set_mem(1'b0, 1'b0, 5'd0);
        @(posedge clk); #1;
        step("rst_cyc1", 7'b0000000);
        step("rst_cyc2", 7'b0000000);
        rst = 1'b0;
        step("post_rst", 7'b0000000);

        // load in EX feeding BEQ rs: two stall cycles, then taken resolve
        step("ld_entry", 7'b1110000);
        set_ex(1'b0, 1'b0, 5'd0);
        set_mem(1'b1, 1'b1, 5'd5);
        step("ld_stall2", 7'b1110000);
        set_mem(1'b0, 1'b0, 5'd0);
        step("ld_resolve", 7'b0001100);

        // ALU op in EX feeding BNE rt: one stall, then forward B, not taken
        set_br(BNE, 5'd1, 5'd7, 1'b0);
        set_ex(1'b1, 1'b0, 5'd7);
        step("alu_entry", 7'b1110000);
        set_ex(1'b0, 1'b0, 5'd0);
        set_mem(1'b1, 1'b0, 5'd7);
        step("alu_resolve", 7'b0000001);
`ifdef BRANCH_STATS_EN
        checks++;
        assert (stat_branches === 32'd2) else begin
            errors++;
            $error("FAIL stat_br got=%0d expected=2", stat_branches);
        end
        checks++;
        assert (stat_taken === 32'd1) else begin
            errors++;
            $error("FAIL stat_tk got=%0d expected=1", stat_taken);
        end
        checks++;
        assert (stat_stall_cycles === 32'd3) else begin
            errors++;
            $error("FAIL stat_st got=%0d expected=3", stat_stall_cycles);
        end
`endif
        set_br(NOB, 5'd7, 5'd7, 1'b1);
        step("no_branch", 7'b0000000);

        // r0 writers never create a dependence; same-cycle redirect
        set_br(BGTZ, 5'd3, 5'd0, 1'b1);
        set_ex(1'b1, 1'b0, 5'd0);
        set_mem(1'b1, 1'b0, 5'd0);
        step("bgtz_r0", 7'b0001100);
        set_br(BGTZ, 5'd3, 5'd9, 1'b0);
        set_ex(1'b1, 1'b0, 5'd9);
        set_mem(1'b0, 1'b0, 5'd0);
        step("bgtz_rt_unused", 7'b0000000);
        set_br(BEQ, 5'd3, 5'd9, 1'b0);
        step("beq_rt_dep", 7'b1110000);
        set_ex(1'b0, 1'b0, 5'd0);
        step("beq_rt_res", 7'b0000000);

        // load in MEM counts as a short stall; forward A from ALU result
        set_br(BNE, 5'd6, 5'd2, 1'b1);
        set_mem(1'b1, 1'b1, 5'd6);
        step("memld_entry", 7'b1110000);
        set_mem(1'b1, 1'b0, 5'd6);
        step("memld_res_fwd", 7'b0001110);
        set_mem(1'b0, 1'b0, 5'd0);

        // external freeze in mid-STALL
        set_br(BEQ, 5'd4, 5'd0, 1'b0);
        set_ex(1'b1, 1'b1, 5'd4);
        step("frz_entry", 7'b1110000);
        set_ex(1'b0, 1'b0, 5'd0);
        ext_stall = 1'b1;
        step("frz_1", 7'b0000000);
        step("frz_2", 7'b0000000);
        step("frz_3", 7'b0000000);
        ext_stall = 1'b0;
        step("frz_resume", 7'b1110000);
        step("frz_resolve", 7'b0000000);

        // reset while stalled returns to IDLE
        set_ex(1'b1, 1'b1, 5'd4);
        step("rs_entry", 7'b1110000);
        set_ex(1'b0, 1'b0, 5'd0);
        rst = 1'b1;
        step("rs_in_stall", 7'b0000000);
        rst = 1'b0;
        step("rs_post", 7'b0000000);
        set_br(BEQ, 5'd2, 5'd0, 1'b1);
        step("rs_idle_res", 7'b0001100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
